// File: rtl/cpu_pkg.sv
// cpu_pkg: constants shared by the fetch unit and the controller.
// PC-source encodings, the NOOP word, opcode classes and a sign-extension helper.
package cpu_pkg;

    localparam logic [1:0] PCSRC_ALU  = 2'b00;
    localparam logic [1:0] PCSRC_BR   = 2'b01;
    localparam logic [1:0] PCSRC_JMP  = 2'b10;
    localparam logic [1:0] PCSRC_RSVD = 2'b11;

    localparam logic [31:0] INSTR_NOOP = 32'h0000_0000;

    // Opcode classes decoded by the controller from instr[31:26].
    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_JUMP  = 6'b000010;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// fetch_perf_cnt: pair of saturating 32-bit event counters (IR loads, redirects).
// Only instantiated by fetch_unit when FETCH_PERF_CNT_EN is defined.
module fetch_perf_cnt
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_inc,
    input  logic        taken_inc,
    output logic [31:0] fetch_cnt,
    output logic [31:0] taken_cnt
);

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt <= '0;
            taken_cnt <= '0;
        end else begin
            if (fetch_inc && fetch_cnt != CNT_MAX) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (taken_inc && taken_cnt != CNT_MAX) begin
                taken_cnt <= taken_cnt + 32'd1;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC and instruction register of the multicycle CPU; applies controller PC commands.
// Define FETCH_PERF_CNT_EN to add the fetch_cnt/taken_cnt performance counters.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int PC_W    = 16,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pc_write,
    input  logic               mem_read,
    input  logic [1:0]         pc_source,
    input  logic               branch_type,
    input  logic               rs_eq,
    input  logic [31:0]        alu_result,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [PC_W-1:0]    imem_addr,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    br_target,
    output logic               redirect
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        fetch_cnt,
    output logic [31:0]        taken_cnt
`endif
);

    logic [PC_W-1:0] pc_next;
    logic            redirect_next;
    logic [PC_W-1:0] br_next;
    logic            unused_alu_hi;

    assign imem_addr     = pc;
    assign unused_alu_hi = ^alu_result[31:PC_W];

    // Target relative to the PC of the word being fetched, wrapping at PC_W bits.
    assign br_next = PC_W'(32'(pc) + 32'd1 + sext16(imem_rdata[15:0]));

    always_comb begin
        pc_next       = pc;
        redirect_next = 1'b0;
        if (pc_write) begin
            if (branch_type) begin
                if (rs_eq) begin
                    pc_next       = br_target;
                    redirect_next = 1'b1;
                end
            end else begin
                case (pc_source)
                    PCSRC_ALU: pc_next = alu_result[PC_W-1:0];
                    PCSRC_BR: begin
                        pc_next       = br_target;
                        redirect_next = 1'b1;
                    end
                    // Jump uses the instruction already latched in IR, not the word on the bus.
                    PCSRC_JMP: begin
                        pc_next       = instr[PC_W-1:0];
                        redirect_next = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc        <= '0;
            instr     <= INSTR_W'(INSTR_NOOP);
            br_target <= '0;
            redirect  <= 1'b0;
        end else begin
            pc       <= pc_next;
            redirect <= redirect_next;
            if (mem_read) begin
                instr     <= imem_rdata;
                br_target <= br_next;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    fetch_perf_cnt u_perf (
        .clk       (clk),
        .reset     (reset),
        .fetch_inc (mem_read),
        .taken_inc (redirect_next),
        .fetch_cnt (fetch_cnt),
        .taken_cnt (taken_cnt)
    );
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset && pc_write && !branch_type) begin
            assert (pc_source != PCSRC_RSVD);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random checks of fetch_unit against a modular-arithmetic reference model.
// Define FETCH_PERF_CNT_EN to also check the performance counters.
module tb_fetch_unit;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 32;
    localparam int PC_MOD  = 1 << PC_W;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               pc_write = 1'b0;
    logic               mem_read = 1'b0;
    logic [1:0]         pc_source = 2'b00;
    logic               branch_type = 1'b0;
    logic               rs_eq = 1'b0;
    logic [31:0]        alu_result = '0;
    logic [INSTR_W-1:0] imem_rdata = '0;
    logic [PC_W-1:0]    imem_addr;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    br_target;
    logic               redirect;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]        fetch_cnt;
    logic [31:0]        taken_cnt;
`endif

    fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_write    (pc_write),
        .mem_read    (mem_read),
        .pc_source   (pc_source),
        .branch_type (branch_type),
        .rs_eq       (rs_eq),
        .alu_result  (alu_result),
        .imem_rdata  (imem_rdata),
        .imem_addr   (imem_addr),
        .pc          (pc),
        .instr       (instr),
        .br_target   (br_target),
        .redirect    (redirect)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt   (fetch_cnt),
        .taken_cnt   (taken_cnt)
`endif
    );

    // Clock
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Scoreboard: expected PC after each edge
    logic [PC_W-1:0] exp_q[$];

    // Reference model state, kept as plain integers
    int          m_pc;
    int          m_br;
    logic [31:0] m_instr;
    bit          m_redir;
    int          m_fcnt;
    int          m_tcnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Drive one cycle, advance the model, then compare everything after the edge.
    task automatic step(input bit rst, input bit pw, input bit mr, input logic [1:0] src,
                        input bit bt, input bit eq, input logic [31:0] alu, input logic [31:0] rd,
                        input string tag);
        int n_pc;
        bit n_red;
        int imm;
        reset       = rst;
        pc_write    = pw;
        mem_read    = mr;
        pc_source   = src;
        branch_type = bt;
        rs_eq       = eq;
        alu_result  = alu;
        imem_rdata  = rd;
        if (rst) begin
            n_pc = 0; n_red = 0;
            m_br = 0; m_instr = 32'h0; m_fcnt = 0; m_tcnt = 0;
        end else begin
            n_pc  = m_pc;
            n_red = 0;
            if (pw && bt) begin
                if (eq) begin n_pc = m_br; n_red = 1; end
            end else if (pw) begin
                if (src == 2'd0) n_pc = int'(alu % 32'(PC_MOD));
                else if (src == 2'd1) begin n_pc = m_br; n_red = 1; end
                else if (src == 2'd2) begin n_pc = int'(m_instr % 32'(PC_MOD)); n_red = 1; end
            end
            if (mr) begin
                imm     = rd[15] ? int'(rd[15:0]) - 65536 : int'(rd[15:0]);
                m_br    = (((m_pc + 1 + imm) % PC_MOD) + PC_MOD) % PC_MOD;
                m_instr = rd;
                m_fcnt++;
            end
            if (n_red) m_tcnt++;
        end
        m_pc    = n_pc;
        m_redir = n_red;
        exp_q.push_back(PC_W'(n_pc));
        @(posedge clk);
        #1;
        check({tag, ".pc"}, 32'(pc), 32'(exp_q.pop_front()));
        check({tag, ".imem_addr"}, 32'(imem_addr), 32'(m_pc));
        check({tag, ".instr"}, instr, m_instr);
        check({tag, ".br_target"}, 32'(br_target), 32'(m_br));
        check({tag, ".redirect"}, 32'(redirect), 32'(m_redir));
`ifdef FETCH_PERF_CNT_EN
        check({tag, ".fetch_cnt"}, fetch_cnt, 32'(m_fcnt));
        check({tag, ".taken_cnt"}, taken_cnt, 32'(m_tcnt));
`endif
    endtask

    task automatic idle(input string tag);
        step(0, 0, 0, 2'b00, 0, 0, 32'h0, 32'h0, tag);
    endtask

    initial begin
        logic [1:0] src;
        bit pw, bt;

        m_pc = 0; m_br = 0; m_instr = 0; m_redir = 0; m_fcnt = 0; m_tcnt = 0;

        // Reset held two cycles while fetch/PC commands are active
        step(1, 1, 1, 2'b00, 0, 0, 32'h5, 32'hDEAD_BEEF, "reset0");
        step(1, 1, 1, 2'b00, 0, 0, 32'h5, 32'hDEAD_BEEF, "reset1");
        idle("after_reset");

        // Sequential fetch of imem[0]
        step(0, 1, 1, 2'b00, 0, 0, 32'h1, 32'h4400_0001, "seq_fetch");
        check("seq_fetch.instr_const", instr, 32'h4400_0001);
        check("seq_fetch.pc_const", 32'(pc), 32'h1);

        // BEQ: load IR from pc=4 with imm=-2 -> target 3
        step(0, 1, 0, 2'b00, 0, 0, 32'h4, 32'h0, "goto4");
        step(0, 0, 1, 2'b00, 0, 0, 32'h0, 32'h1000_FFFE, "beq_load");
        check("beq_load.br_const", 32'(br_target), 32'h3);
        step(0, 0, 0, 2'b00, 1, 1, 32'h0, 32'h0, "beq_no_pcwrite");
        step(0, 1, 0, 2'b00, 1, 1, 32'h0, 32'h0, "beq_taken");
        check("beq_taken.pc_const", 32'(pc), 32'h3);
        check("beq_taken.redirect_const", 32'(redirect), 32'h1);
        idle("beq_pulse_end");
        step(0, 1, 0, 2'b00, 1, 0, 32'h77, 32'h0, "beq_not_taken");

        // Jump to the address held in IR
        step(0, 0, 1, 2'b00, 0, 0, 32'h0, 32'h0000_0020, "jmp_load");
        step(0, 1, 0, 2'b10, 0, 0, 32'h0, 32'hFFFF_FFFF, "jmp");
        check("jmp.pc_const", 32'(pc), 32'h20);
        idle("jmp_pulse_end");

        // Wrap at the top of the address space; upper ALU bits ignored
        step(0, 1, 0, 2'b00, 0, 0, 32'h0000_FFFF, 32'h0, "to_ffff");
        step(0, 1, 0, 2'b00, 0, 0, 32'h0001_0000, 32'h0, "wrap");
        check("wrap.pc_const", 32'(pc), 32'h0);

        // branch_type overrides a jump source
        step(0, 1, 1, 2'b10, 0, 0, 32'h0, 32'h0000_0010, "prio_load");
        step(0, 1, 0, 2'b10, 1, 1, 32'h0, 32'h0, "prio_branch");

        // Fetch and branch-source PC update on the same edge use the old target
        step(0, 1, 1, 2'b01, 0, 0, 32'h0, 32'h0000_0100, "fetch_and_br");

        // Reset in the middle of a fetch discards the load
        step(1, 1, 1, 2'b00, 0, 0, 32'h9, 32'hCAFE_F00D, "reset_mid");

`ifdef FETCH_PERF_CNT_EN
        step(0, 1, 1, 2'b00, 0, 0, 32'h1, 32'h0000_0040, "cnt_f1");
        step(0, 1, 1, 2'b00, 0, 0, 32'h2, 32'h0000_0041, "cnt_f2");
        step(0, 0, 1, 2'b00, 0, 0, 32'h0, 32'h0000_0042, "cnt_f3");
        step(0, 1, 0, 2'b10, 0, 0, 32'h0, 32'h0, "cnt_jmp");
        check("cnt.fetch_const", fetch_cnt, 32'd3);
        check("cnt.taken_const", taken_cnt, 32'd1);
        step(1, 0, 0, 2'b00, 0, 0, 32'h0, 32'h0, "cnt_reset");
        check("cnt_reset.fetch_const", fetch_cnt, 32'd0);
        check("cnt_reset.taken_const", taken_cnt, 32'd0);
`endif

        // Randomized commands; the reserved source is only sent where it is ignored
        for (int i = 0; i < 400; i++) begin
            pw  = ($urandom_range(0, 3) != 0);
            bt  = ($urandom_range(0, 4) == 0);
            src = 2'($urandom_range(0, 3));
            if (src == 2'b11 && pw && !bt) src = 2'b00;
            step(($urandom_range(0, 63) == 0), pw, $urandom_range(0, 1) == 1, src, bt,
                 $urandom_range(0, 1) == 1, $urandom, $urandom, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
